// File: rtl/tpu_pkg.sv
// Shared TPU definitions: sequencer state codes and array-level constants.
package tpu_pkg;

    localparam int DATA_W  = 8;
    localparam int ARRAY_N = 2;

    // Encoding doubles as the debug phase output.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_FEED    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } mmu_state_t;

endpackage

// File: rtl/mmu_phase_cnt.sv
// Phase counter for the MMU sequencer: clearable up-counter with a
// terminal-count compare against a per-phase limit.
module mmu_phase_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    // Clear wins over enable so a phase change always restarts at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == limit_i);

endmodule

// File: rtl/mmu_sequencer.sv
// MMU sequencer: runs one systolic matrix multiply as
// LOAD_W -> FEED -> DRAIN -> CAPTURE -> DONE. All outputs are decoded from
// registered state only. Optional completed-op counter under
// MMU_SEQ_PERF_CNT_EN (adds port op_count).
module mmu_sequencer
    import tpu_pkg::*;
#(
    parameter int N         = ARRAY_N,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 w_load,
    output logic [$clog2(N)-1:0] w_row,
    output logic                 setup_valid,
    output logic                 setup_clear,
    output logic                 acc_capture,
    output logic [2:0]           phase
`ifdef MMU_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]          op_count
`endif
);

    localparam int RW = $clog2(N);

    localparam logic [CNT_W-1:0] LIM_LOAD  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LIM_FEED  = CNT_W'(2 * N - 2);
    localparam logic [CNT_W-1:0] LIM_DRAIN = CNT_W'(DRAIN_CYC - 1);

    mmu_state_t       state_q, state_d;
    logic             abort_clr_q;
    logic [CNT_W-1:0] cnt, limit;
    logic             tc, cnt_clear, cnt_en;

    // Next-state decode; abort overrides every non-idle transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start && !abort) state_d = ST_LOAD_W;
            ST_LOAD_W:  if (tc) state_d = ST_FEED;
            ST_FEED:    if (tc) state_d = ST_DRAIN;
            ST_DRAIN:   if (tc) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    // Per-phase terminal count; only the counted phases use it.
    always_comb begin
        limit = '0;
        case (state_q)
            ST_LOAD_W: limit = LIM_LOAD;
            ST_FEED:   limit = LIM_FEED;
            ST_DRAIN:  limit = LIM_DRAIN;
            default:   limit = '0;
        endcase
    end

    assign cnt_clear = (state_d != state_q);
    assign cnt_en    = (state_q == ST_LOAD_W) || (state_q == ST_FEED) ||
                       (state_q == ST_DRAIN);

    mmu_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .limit_i (limit),
        .cnt_o   (cnt),
        .tc_o    (tc)
    );

    // State register plus the one-cycle skew-clear request left by an abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            abort_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            abort_clr_q <= abort && (state_q != ST_IDLE);
        end
    end

`ifdef MMU_SEQ_PERF_CNT_EN
    logic [15:0] op_count_q;

    // Completed-operation count, saturating; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count_q <= '0;
        end else if (state_q == ST_DONE && op_count_q != 16'hFFFF) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

    assign phase       = state_q;
    assign busy        = (state_q != ST_IDLE);
    assign w_load      = (state_q == ST_LOAD_W);
    assign w_row       = (state_q == ST_LOAD_W) ? cnt[RW-1:0] : '0;
    assign setup_valid = (state_q == ST_FEED);
    assign acc_capture = (state_q == ST_CAPTURE);
    assign done        = (state_q == ST_DONE);
    assign setup_clear = (state_q == ST_DONE) || abort_clr_q;

endmodule
